// File: rtl/uplink_capture_pkg.sv
// Shared types for the uplink capture path.
//   state_t     : capture FSM states
//   trig_mode_t : trigger-mode encodings on trig_mode_i
//   UPLINK_DATA_W : lpGBT uplink user-data width
package uplink_capture_pkg;

   localparam int unsigned UPLINK_DATA_W = 234;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      TRIG_IMMEDIATE = 2'd0,
      TRIG_PATTERN   = 2'd1,
      TRIG_EXTERNAL  = 2'd2,
      TRIG_RESERVED  = 2'd3
   } trig_mode_t;

endpackage

// File: rtl/uplink_trig_match.sv
// Combinational trigger-condition comparator.
//   mode    : trigger mode (reserved encoding behaves as immediate)
//   slice   : data slice under test
//   pattern : expected value of the slice
//   mask    : 1 = bit compared; all-zero mask matches anything
//   ext     : external trigger level
//   match_c : condition met this cycle (link readiness not included)
module uplink_trig_match
   import uplink_capture_pkg::*;
#(
   parameter int unsigned TRIG_W = 32
) (
   input  logic [1:0]        mode,
   input  logic [TRIG_W-1:0] slice,
   input  logic [TRIG_W-1:0] pattern,
   input  logic [TRIG_W-1:0] mask,
   input  logic              ext,
   output logic              match_c
);

   always_comb begin
      match_c = 1'b1;
      case (trig_mode_t'(mode))
         TRIG_PATTERN:  match_c = (((slice ^ pattern) & mask) == '0);
         TRIG_EXTERNAL: match_c = ext;
         default:       match_c = 1'b1;
      endcase
   end

endmodule

// File: rtl/uplink_frame_capture.sv
// Gates the continuous lpGBT uplink stream into bounded capture windows
// for the dataframe store.
//   clk40_i/rstn_i          : clock, synchronous active-low reset
//   uplinkUserData_i/uplinkrdy_i : uplink data and lock
//   arm_i/abort_i           : start / cancel a window (pulses)
//   trig_*_i, ext_trig_i    : trigger configuration (sampled at arm) and strobe
//   capture_len_i/timeout_i : window length and ARMED timeout (sampled at arm)
//   frame_*_o               : registered captured frame stream
//   busy_o/done_o/err_*_o   : status (done and errors are sticky until re-arm)
module uplink_frame_capture
   import uplink_capture_pkg::*;
#(
   parameter int unsigned DATA_W   = UPLINK_DATA_W,
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned TRIG_LSB = 0,
   parameter int unsigned TRIG_W   = 32
) (
   input  logic              clk40_i,
   input  logic              rstn_i,
   input  logic [DATA_W-1:0] uplinkUserData_i,
   input  logic              uplinkrdy_i,
   input  logic              arm_i,
   input  logic              abort_i,
   input  logic [1:0]        trig_mode_i,
   input  logic [TRIG_W-1:0] trig_pattern_i,
   input  logic [TRIG_W-1:0] trig_mask_i,
   input  logic              ext_trig_i,
   input  logic [CNT_W-1:0]  capture_len_i,
   input  logic [CNT_W-1:0]  timeout_i,
   output logic [DATA_W-1:0] frame_data_o,
   output logic              frame_valid_o,
   output logic              frame_last_o,
   output logic [CNT_W-1:0]  frame_cnt_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_link_o,
   output logic              err_timeout_o
);

   state_t            state;
   logic [CNT_W-1:0]  len_q;
   logic [CNT_W-1:0]  timeout_q;
   logic [CNT_W-1:0]  wait_cnt;
   logic [1:0]        mode_q;
   logic [TRIG_W-1:0] pattern_q;
   logic [TRIG_W-1:0] mask_q;

   logic              trig_c;
   logic              accept_c;
   logic [CNT_W-1:0]  frame_next_c;

   uplink_trig_match #(.TRIG_W(TRIG_W)) u_trig (
      .mode    (mode_q),
      .slice   (uplinkUserData_i[TRIG_LSB +: TRIG_W]),
      .pattern (pattern_q),
      .mask    (mask_q),
      .ext     (ext_trig_i),
      .match_c (trig_c)
   );

   // A frame is taken on the trigger cycle in ARMED and on every ready cycle in CAPTURE.
   assign accept_c     = uplinkrdy_i & ((state == ST_CAPTURE) | ((state == ST_ARMED) & trig_c));
   assign frame_next_c = frame_cnt_o + CNT_W'(1);

   // Capture FSM, counters and output register.
   always_ff @(posedge clk40_i) begin
      if (!rstn_i) begin
         state         <= ST_IDLE;
         len_q         <= '0;
         timeout_q     <= '0;
         wait_cnt      <= '0;
         mode_q        <= '0;
         pattern_q     <= '0;
         mask_q        <= '0;
         frame_data_o  <= '0;
         frame_valid_o <= 1'b0;
         frame_last_o  <= 1'b0;
         frame_cnt_o   <= '0;
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
         err_link_o    <= 1'b0;
         err_timeout_o <= 1'b0;
      end else begin
         frame_valid_o <= 1'b0;
         frame_last_o  <= 1'b0;
         if (abort_i) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
         end else begin
            case (state)
               ST_IDLE, ST_DONE: begin
                  if (arm_i && (capture_len_i != '0)) begin
                     len_q         <= capture_len_i;
                     timeout_q     <= timeout_i;
                     mode_q        <= trig_mode_i;
                     pattern_q     <= trig_pattern_i;
                     mask_q        <= trig_mask_i;
                     wait_cnt      <= '0;
                     frame_cnt_o   <= '0;
                     done_o        <= 1'b0;
                     err_link_o    <= 1'b0;
                     err_timeout_o <= 1'b0;
                     busy_o        <= 1'b1;
                     state         <= ST_ARMED;
                  end
               end
               ST_ARMED, ST_CAPTURE: begin
                  if (accept_c) begin
                     frame_data_o  <= uplinkUserData_i;
                     frame_valid_o <= 1'b1;
                     frame_cnt_o   <= frame_next_c;
                     if (frame_next_c == len_q) begin
                        frame_last_o <= 1'b1;
                        done_o       <= 1'b1;
                        busy_o       <= 1'b0;
                        state        <= ST_DONE;
                     end else begin
                        state <= ST_CAPTURE;
                     end
                  end else if (state == ST_CAPTURE) begin
                     err_link_o <= 1'b1;
                     busy_o     <= 1'b0;
                     state      <= ST_IDLE;
                  end else if (timeout_q != '0) begin
                     // Trigger has priority, so expiry only fires on a no-trigger cycle.
                     wait_cnt <= wait_cnt + CNT_W'(1);
                     if ((wait_cnt + CNT_W'(1)) == timeout_q) begin
                        err_timeout_o <= 1'b1;
                        busy_o        <= 1'b0;
                        state         <= ST_IDLE;
                     end
                  end
               end
               default: begin
                  busy_o <= 1'b0;
                  state  <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/uplink_frame_capture.md
Name: uplink_frame_capture

Overview:
- Sits directly upstream of the dataframe store, in the clk40 domain, between the lpGBT uplink user-data bus and the store's uplinkUserData_i/uplinkrdy_i inputs.
- Gates the continuous uplink stream into bounded capture windows: arm, wait for a trigger condition (immediate, pattern match on a data slice, or external strobe), then forward exactly N frames with valid/last qualifiers.
- Reports link-loss and timeout errors so software never reads a partial window as good.

Parameters:
- DATA_W, 234, uplink user-data width
- CNT_W, 16, width of the capture-length, timeout and frame counters
- TRIG_LSB, 0, LSB of the data slice compared for pattern triggering
- TRIG_W, 32, width of the compared slice (TRIG_LSB+TRIG_W <= DATA_W)

Ports:
- clk40_i  in  1  40 MHz uplink clock; the only clock
- rstn_i  in  1  synchronous active-low reset
- uplinkUserData_i  in  DATA_W  lpGBT uplink user data
- uplinkrdy_i  in  1  lpGBT uplink ready/locked
- arm_i  in  1  single-cycle pulse; starts a capture from IDLE or DONE
- abort_i  in  1  single-cycle pulse; forces IDLE
- trig_mode_i  in  2  0 = immediate, 1 = pattern, 2 = external, 3 = reserved (treated as immediate)
- trig_pattern_i  in  TRIG_W  pattern compared against the data slice
- trig_mask_i  in  TRIG_W  1 = bit compared
- ext_trig_i  in  1  external trigger, level-sampled
- capture_len_i  in  CNT_W  frames per window; 0 = arm ignored
- timeout_i  in  CNT_W  cycles to wait in ARMED; 0 = no timeout
- frame_data_o  out  DATA_W  registered captured frame (feeds the store's uplinkUserData_i)
- frame_valid_o  out  1  frame qualifier (feeds the store's uplinkrdy_i)
- frame_last_o  out  1  marks the final frame of a window
- frame_cnt_o  out  CNT_W  frames emitted in the current/last window
- busy_o  out  1  state is ARMED or CAPTURE
- done_o  out  1  sticky; window completed cleanly
- err_link_o  out  1  sticky; uplinkrdy_i dropped during CAPTURE
- err_timeout_o  out  1  sticky; ARMED timed out

Behaviour:
- Reset (rstn_i low at clk40_i edge):
  - State returns to IDLE.
  - All outputs reset to 0, including frame_data_o and frame_cnt_o.
  - Reset mid-capture discards the window with no frame_last_o.
- States and transitions:
  - IDLE: on arm_i with capture_len_i != 0, latch len/timeout/mode/pattern/mask, clear frame_cnt_o, done_o and both error flags, then go to ARMED.
  - ARMED:
    - Trigger when uplinkrdy_i & cond, where cond is: mode 0 = 1; mode 1 = ((slice ^ pattern) & mask) == 0; mode 2 = ext_trig_i.
    - An all-zero mask matches any frame.
    - On trigger, go to CAPTURE. The triggering frame is frame 0 of the window.
    - If timeout != 0, a wait counter increments each ARMED cycle. When it reaches timeout with no trigger, set err_timeout_o and go to IDLE.
  - CAPTURE:
    - Each cycle with uplinkrdy_i = 1 emits one frame.
    - If uplinkrdy_i = 0, set err_link_o, go to IDLE, and emit no frame_last_o.
    - When the emitted count reaches len, assert frame_last_o with that frame, set done_o, and go to DONE.
  - DONE: holds outputs quiet. arm_i re-arms exactly as from IDLE.
- Latency: exactly 1 cycle. A frame is accepted at edge k and frame_data_o/frame_valid_o are valid after edge k, for one cycle.
  - frame_valid_o is never high for two frames without uplinkrdy_i high on both source cycles.
- frame_data_o holds its last value when frame_valid_o = 0.
- frame_cnt_o increments per emitted frame and saturates at len; no wrap.
  - capture_len_i = 2^CNT_W-1 is legal.
- Simultaneous events:
  - abort_i beats everything: go to IDLE, no last, no done, error flags untouched.
  - arm_i while ARMED or CAPTURE is ignored.
  - A trigger on the same cycle as the timeout expiry counts as a trigger; no error.
- len = 1: the trigger frame carries both frame_valid_o and frame_last_o, and the state goes ARMED -> DONE via CAPTURE bookkeeping in one accepted frame.
- Config inputs are sampled only at arm and may change freely afterwards.

Decomposition:
- Shared package (uplink_capture_pkg):
  - State enum: IDLE, ARMED, CAPTURE, DONE.
  - trig_mode encodings.
  - UPLINK_DATA_W = 234.
- Sub-module uplink_trig_match:
  - Combinational mode/pattern/mask/ext comparator.
  - Reused by future trigger stages.
- The FSM, counters and output register stay in uplink_frame_capture.

Test Plan:
- Immediate mode, len = 4, uplinkrdy_i = 1, data = incrementing 0..: arm -> frames 0,1,2,3 emitted, last on 3, done_o = 1, frame_cnt_o = 4, valid exactly 4 cycles.
- Pattern mode, mask = 0xFFFF0000, pattern = 0xCAFE0000, matching frame injected at cycle 20: first emitted frame = that frame, 1-cycle latency, no earlier valids.
- Timeout = 10, pattern never matches: err_timeout_o = 1 after 10 ARMED cycles, busy_o = 0, zero valids.
- uplinkrdy_i dropped after 3 of 8 frames: 3 valids, no last, err_link_o = 1, done_o = 0; subsequent arm clears err_link_o.
- len = 1, external mode, ext_trig_i pulsed together with arm_i one cycle later: single frame with valid and last both high, done_o = 1.
- rstn_i low during CAPTURE and abort_i during ARMED: all outputs 0 / state IDLE on the next cycle, no frame_last_o emitted.
